// File: rtl/ioctl_upload_reader.sv
// HPS upload readback: serves ioctl byte reads from a core RAM port
// while the core is held paused so the saved image stays consistent.
module ioctl_upload_reader #(
    parameter int         ADDR_W = 16,
    parameter int         RAM_AW = 11,
    parameter int         LEN    = 2048,
    parameter int         RD_LAT = 1,
    parameter logic [7:0] PAD    = 8'hFF
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_upload,
    input  logic              ioctl_rd,
    input  logic [ADDR_W-1:0] ioctl_addr,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic              pause_req,
    input  logic              pause_ack,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_rd,
    input  logic [7:0]        ram_q,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PAUSE,
        S_READY,
        S_FETCH,
        S_PADB,
        S_RELEASE
    } state_t;

    localparam logic [ADDR_W:0] LEN_W = (ADDR_W + 1)'(LEN);
    localparam logic [1:0]      LAT_W = 2'(RD_LAT);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [7:0]        r_din;
    logic [7:0]        w_din_nxt;
    logic              r_wait;
    logic              w_wait_nxt;
    logic              r_preq;
    logic              w_preq_nxt;
    logic [RAM_AW-1:0] r_addr;
    logic [RAM_AW-1:0] w_addr_nxt;
    logic              r_rd;
    logic              w_rd_nxt;
    logic [1:0]        r_cnt;
    logic [1:0]        w_cnt_nxt;
    logic              w_in_range;
    logic              w_abort;

    // Range check on the full HPS address so high bits never alias into RAM
    assign w_in_range = ({1'b0, ioctl_addr} < LEN_W);
    assign w_abort    = !ioctl_upload &&
                        (r_state inside {S_PAUSE, S_READY, S_FETCH, S_PADB});

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_din   <= 8'h00;
            r_wait  <= 1'b0;
            r_preq  <= 1'b0;
            r_addr  <= '0;
            r_rd    <= 1'b0;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_din   <= w_din_nxt;
            r_wait  <= w_wait_nxt;
            r_preq  <= w_preq_nxt;
            r_addr  <= w_addr_nxt;
            r_rd    <= w_rd_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_din_nxt   = r_din;
        w_wait_nxt  = r_wait;
        w_preq_nxt  = r_preq;
        w_addr_nxt  = r_addr;
        w_rd_nxt    = 1'b0;
        w_cnt_nxt   = r_cnt;
        if (w_abort) begin
            w_state_nxt = S_RELEASE;
            w_preq_nxt  = 1'b0;
            w_wait_nxt  = 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (ioctl_upload) begin
                        w_state_nxt = S_PAUSE;
                        w_preq_nxt  = 1'b1;
                        w_wait_nxt  = 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (pause_ack) begin
                        w_state_nxt = S_READY;
                        w_wait_nxt  = 1'b0;
                    end
                end
                S_READY: begin
                    if (ioctl_rd) begin
                        w_wait_nxt = 1'b1;
                        if (w_in_range) begin
                            w_state_nxt = S_FETCH;
                            w_addr_nxt  = ioctl_addr[RAM_AW-1:0];
                            w_rd_nxt    = 1'b1;
                            w_cnt_nxt   = 2'd0;
                        end else begin
                            w_state_nxt = S_PADB;
                        end
                    end
                end
                S_FETCH: begin
                    // r_cnt counts cycles since ram_addr became valid
                    if (r_cnt == LAT_W) begin
                        w_state_nxt = S_READY;
                        w_din_nxt   = ram_q;
                        w_wait_nxt  = 1'b0;
                    end else begin
                        w_cnt_nxt = r_cnt + 2'd1;
                    end
                end
                S_PADB: begin
                    w_state_nxt = S_READY;
                    w_din_nxt   = PAD;
                    w_wait_nxt  = 1'b0;
                end
                S_RELEASE: begin
                    w_state_nxt = S_IDLE;
                    w_preq_nxt  = 1'b0;
                    w_wait_nxt  = 1'b0;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_preq_nxt  = 1'b0;
                    w_wait_nxt  = 1'b0;
                end
            endcase
        end
    end

    assign ioctl_din  = r_din;
    assign ioctl_wait = r_wait;
    assign pause_req  = r_preq;
    assign ram_addr   = r_addr;
    assign ram_rd     = r_rd;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_ioctl_upload_reader.sv
// Bench for ioctl_upload_reader: three instances (RD_LAT 1..3) share
// stimulus and are checked against a byte/latency model of the upload path.
module tb_ioctl_upload_reader;

    localparam int         LEN = 2048;
    localparam logic [7:0] PAD = 8'hFF;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             upload;
    logic             rd;
    logic [15:0]      addr;
    logic             pack;
    logic [2:0][7:0]  din;
    logic [2:0]       wt;
    logic [2:0]       preq;
    logic [2:0][10:0] raddr;
    logic [2:0]       rrd;
    logic [2:0][7:0]  rq;
    logic [2:0]       bsy;

    logic [7:0] mem [LEN];
    int         rd_cnt [3];
    int         exp_rd;
    logic [7:0] last_din;
    int         total;
    int         bad;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        logic [7:0] q [3];
        ioctl_upload_reader #(
            .ADDR_W(16), .RAM_AW(11), .LEN(LEN), .RD_LAT(g + 1), .PAD(PAD)
        ) u_dut (
            .clk_sys(clk), .reset_n(reset_n),
            .ioctl_upload(upload), .ioctl_rd(rd), .ioctl_addr(addr),
            .ioctl_din(din[g]), .ioctl_wait(wt[g]),
            .pause_req(preq[g]), .pause_ack(pack),
            .ram_addr(raddr[g]), .ram_rd(rrd[g]), .ram_q(rq[g]),
            .busy(bsy[g])
        );
        always @(posedge clk) begin
            q[0] <= mem[raddr[g]];
            q[1] <= q[0];
            q[2] <= q[1];
        end
        assign rq[g] = q[g];
    end

    always @(posedge clk)
        for (int g = 0; g < 3; g++)
            if (rrd[g] === 1'b1) rd_cnt[g] <= rd_cnt[g] + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_byte(input logic [15:0] a);
        if (a < LEN) return mem[a[10:0]];
        return PAD;
    endfunction

    function automatic bit ref_rd(input logic [15:0] a);
        return a < LEN;
    endfunction

    task automatic chk_zero(input string nm);
        for (int g = 0; g < 3; g++) begin
            chk({nm, "_din"}, din[g], 0);
            chk({nm, "_wait"}, wt[g], 0);
            chk({nm, "_preq"}, preq[g], 0);
            chk({nm, "_raddr"}, raddr[g], 0);
            chk({nm, "_rrd"}, rrd[g], 0);
            chk({nm, "_busy"}, bsy[g], 0);
        end
    endtask

    // One HPS read; optional ignored second strobe while wait is high
    task automatic do_read(input logic [15:0] a, input logic [7:0] e,
                           input bit e_rd, input bit dbl);
        int lat;
        for (int g = 0; g < 3; g++) chk("pre_wait", wt[g], 0);
        rd = 1'b1;
        addr = a;
        tick();
        rd = 1'b0;
        if (dbl) begin
            rd = 1'b1;
            addr = a ^ 16'h0155;
        end
        if (e_rd) exp_rd++;
        for (int g = 0; g < 3; g++) begin
            chk("t1_ram_rd", rrd[g], 32'(e_rd));
            chk("t1_wait", wt[g], 1);
            if (e_rd) chk("t1_ram_addr", raddr[g], 32'(a[10:0]));
        end
        tick();
        rd = 1'b0;
        for (int k = 2; k <= 5; k++) begin
            for (int g = 0; g < 3; g++) begin
                lat = e_rd ? g + 3 : 2;
                chk("tk_ram_rd", rrd[g], 0);
                if (k < lat) begin
                    chk("tk_wait_hi", wt[g], 1);
                end else begin
                    chk("tk_wait_lo", wt[g], 0);
                    chk("tk_din", din[g], 32'(e));
                end
            end
            if (k < 5) tick();
        end
        last_din = e;
    endtask

    task automatic start_session();
        upload = 1'b1;
        tick();
        for (int c = 1; c <= 5; c++) begin
            if (c == 3) begin
                rd = 1'b1;
                addr = 16'h0000;
            end else begin
                rd = 1'b0;
            end
            if (c == 5) pack = 1'b1;
            for (int g = 0; g < 3; g++) begin
                chk("pause_preq", preq[g], 1);
                chk("pause_wait", wt[g], 1);
                chk("pause_busy", bsy[g], 1);
            end
            tick();
        end
        rd = 1'b0;
        for (int g = 0; g < 3; g++) begin
            chk("ready_wait", wt[g], 0);
            chk("ready_preq", preq[g], 1);
        end
    endtask

    task automatic end_session();
        upload = 1'b0;
        tick();
        pack = 1'b0;
        for (int g = 0; g < 3; g++) begin
            chk("rel_preq", preq[g], 0);
            chk("rel_wait", wt[g], 0);
            chk("rel_busy", bsy[g], 1);
        end
        tick();
        for (int g = 0; g < 3; g++) chk("idle_busy", bsy[g], 0);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        bit          r;
    } vec_t;

    vec_t tbl [6];

    initial begin
        logic [15:0] ra;
        total = 0;
        bad = 0;
        exp_rd = 0;
        last_din = 8'h00;
        reset_n = 1'b0;
        upload = 1'b0;
        rd = 1'b0;
        addr = 16'h0000;
        pack = 1'b0;
        for (int i = 0; i < LEN; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[11'h012] = 8'hA5;
        tbl[0] = '{16'h0012, 8'hA5, 1'b1};
        tbl[1] = '{16'h0800, 8'hFF, 1'b0};
        tbl[2] = '{16'h07FF, 8'hA5, 1'b1};
        tbl[3] = '{16'h1012, 8'hFF, 1'b0};
        tbl[4] = '{16'h0000, 8'h5A, 1'b1};
        tbl[5] = '{16'hFFFF, 8'hFF, 1'b0};

        tick();
        tick();
        chk_zero("reset");
        reset_n = 1'b1;

        rd = 1'b1;
        tick();
        rd = 1'b0;
        for (int g = 0; g < 3; g++) begin
            chk("idle_rd_busy", bsy[g], 0);
            chk("idle_rd_ram_rd", rrd[g], 0);
            chk("idle_rd_wait", wt[g], 0);
        end
        tick();

        start_session();
        foreach (tbl[i]) do_read(tbl[i].a, tbl[i].d, tbl[i].r, i[0]);

        // Upload dropped while a fetch is in flight
        rd = 1'b1;
        addr = 16'h0100;
        tick();
        rd = 1'b0;
        upload = 1'b0;
        exp_rd++;
        for (int g = 0; g < 3; g++) chk("ab_ram_rd", rrd[g], 1);
        tick();
        for (int g = 0; g < 3; g++) begin
            chk("ab_preq", preq[g], 0);
            chk("ab_wait", wt[g], 0);
            chk("ab_busy", bsy[g], 1);
            chk("ab_din", din[g], 32'(last_din));
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            for (int g = 0; g < 3; g++) begin
                chk("ab_idle_busy", bsy[g], 0);
                chk("ab_hold_din", din[g], 32'(last_din));
            end
        end
        pack = 1'b0;
        start_session();
        do_read(16'h0100, ref_byte(16'h0100), 1'b1, 1'b0);

        for (int i = 0; i < LEN; i++) begin
            ra = 16'(i);
            do_read(ra, ref_byte(ra), ref_rd(ra), (i % 7) == 3);
        end
        end_session();

        for (int i = 0; i < LEN; i++) mem[i] = 8'($urandom);
        tick();
        start_session();
        pack = 1'b0;
        for (int i = 0; i < 300; i++) begin
            ra = 16'($urandom_range(0, 16'h1FFF));
            if ($urandom_range(0, 9) == 0) ra = 16'($urandom);
            do_read(ra, ref_byte(ra), ref_rd(ra), $urandom_range(0, 3) == 0);
        end

        // Reset while the RD_LAT=2 instance is mid-fetch
        rd = 1'b1;
        addr = 16'h0042;
        tick();
        rd = 1'b0;
        exp_rd++;
        reset_n = 1'b0;
        upload = 1'b0;
        pack = 1'b0;
        tick();
        chk_zero("rst_mid");
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            for (int g = 0; g < 3; g++) chk("rst_after_rrd", rrd[g], 0);
        end

        for (int g = 0; g < 3; g++) chk("ram_rd_count", rd_cnt[g], exp_rd);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
